// File: rtl/shift_pkg.sv
// rtl/shift_pkg.sv - shared encodings for the sequential shifter and its step datapath
package shift_pkg;

    localparam logic [1:0] OP_LOGIC = 2'b00;
    localparam logic [1:0] OP_ARITH = 2'b01;
    localparam logic [1:0] OP_ROT   = 2'b10;
    localparam logic [1:0] OP_PASS  = 2'b11;

    localparam logic DIR_LEFT  = 1'b0;
    localparam logic DIR_RIGHT = 1'b1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_step.sv
// rtl/shift_step.sv - combinational shift of a value by k (0..STEP) positions
module shift_step
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int KW    = $clog2(STEP + 1)
) (
    input  logic [WIDTH-1:0] value,
    input  logic [KW-1:0]    k,
    input  logic [1:0]       op,
    input  logic             dir,
    output logic [WIDTH-1:0] result
);

    logic [2*WIDTH-1:0] rot_left;
    logic [2*WIDTH-1:0] rot_right;

    // Rotations shift a doubled copy so k==WIDTH still wraps back to the original value.
    always_comb begin
        rot_left  = {value, value} << k;
        rot_right = {value, value} >> k;
        result    = value;
        case (op)
            OP_LOGIC: result = (dir == DIR_LEFT) ? (value << k) : (value >> k);
            OP_ARITH: result = (dir == DIR_LEFT) ? (value << k)
                                                 : WIDTH'($signed(value) >>> k);
            OP_ROT:   result = (dir == DIR_LEFT) ? rot_left[2*WIDTH-1:WIDTH]
                                                 : rot_right[WIDTH-1:0];
            default:  result = value;
        endcase
    end

endmodule

// File: rtl/seq_shift_unit.sv
// rtl/seq_shift_unit.sv - multi-cycle shifter with valid/ready handshakes on both sides
module seq_shift_unit
    import shift_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int STEP  = 1,
    parameter int AW    = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [AW-1:0]    in_amt,
    input  logic [1:0]       in_op,
    input  logic             in_dir,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int KW = $clog2(STEP + 1);

    state_t            state_q, state_d;
    logic [WIDTH-1:0]  data_q, data_d;
    logic [AW-1:0]     rem_q, rem_d;
    logic [1:0]        op_q, op_d;
    logic              dir_q, dir_d;
    logic [WIDTH-1:0]  out_data_q, out_data_d;
    logic [KW-1:0]     k;
    logic [WIDTH-1:0]  step_out;

    assign in_ready  = (state_q == IDLE) && !rst;
    assign out_valid = (state_q == DONE);
    assign busy      = (state_q != IDLE);
    assign out_data  = out_data_q;

    // Step size for this cycle: a full STEP unless fewer positions remain.
    always_comb begin
        k = KW'(STEP);
        if (int'(rem_q) < STEP) begin
            k = KW'(rem_q);
        end
    end

    shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .value  (data_q),
        .k      (k),
        .op     (op_q),
        .dir    (dir_q),
        .result (step_out)
    );

    // Next-state and datapath updates for accept, per-step shifting and result hand-off.
    always_comb begin
        state_d    = state_q;
        data_d     = data_q;
        rem_d      = rem_q;
        op_d       = op_q;
        dir_d      = dir_q;
        out_data_d = out_data_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    data_d = in_data;
                    op_d   = in_op;
                    dir_d  = in_dir;
                    if (in_amt == '0 || in_op == OP_PASS) begin
                        rem_d      = '0;
                        out_data_d = in_data;
                        state_d    = DONE;
                    end else begin
                        rem_d   = in_amt;
                        state_d = SHIFT;
                    end
                end
            end
            SHIFT: begin
                data_d = step_out;
                rem_d  = rem_q - AW'(k);
                if (rem_d == '0) begin
                    out_data_d = step_out;
                    state_d    = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register; reset discards any in-flight or pending result.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            data_q     <= '0;
            rem_q      <= '0;
            op_q       <= '0;
            dir_q      <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            data_q     <= data_d;
            rem_q      <= rem_d;
            op_q       <= op_d;
            dir_q      <= dir_d;
            out_data_q <= out_data_d;
        end
    end

endmodule

// File: tb/tb_seq_shift_unit.sv
// tb/tb_seq_shift_unit.sv - randomized self-checking bench for seq_shift_unit
module tb_seq_shift_unit;
    import shift_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;

    logic        a_in_valid, a_in_ready, a_in_dir, a_out_valid, a_out_ready, a_busy;
    logic [7:0]  a_in_data, a_out_data;
    logic [2:0]  a_in_amt;
    logic [1:0]  a_in_op;

    logic        b_in_valid, b_in_ready, b_in_dir, b_out_valid, b_out_ready, b_busy;
    logic [15:0] b_in_data, b_out_data;
    logic [3:0]  b_in_amt;
    logic [1:0]  b_in_op;

    int n_tests = 0;
    int n_fail  = 0;

    seq_shift_unit #(.WIDTH(8), .STEP(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .in_data(a_in_data),
        .in_amt(a_in_amt), .in_op(a_in_op), .in_dir(a_in_dir),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .out_data(a_out_data),
        .busy(a_busy)
    );

    seq_shift_unit #(.WIDTH(16), .STEP(4)) u_dut_b (
        .clk(clk), .rst(rst),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .in_data(b_in_data),
        .in_amt(b_in_amt), .in_op(b_in_op), .in_dir(b_in_dir),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .out_data(b_out_data),
        .busy(b_busy)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: each result bit is looked up from its source position in the operand.
    function automatic logic [15:0] ref_shift(input logic [15:0] d, input int amt,
                                              input logic [1:0] op, input logic dir,
                                              input int w);
        logic [15:0] r;
        int src;
        int idx;
        r = '0;
        if (op == OP_PASS) return d;
        for (int i = 0; i < w; i++) begin
            src = (dir == DIR_RIGHT) ? i + amt : i - amt;
            if (src >= 0 && src < w) begin
                r[i] = d[src[3:0]];
            end else if (op == OP_ROT) begin
                idx  = ((src % w) + w) % w;
                r[i] = d[idx[3:0]];
            end else if (op == OP_ARITH && dir == DIR_RIGHT) begin
                r[i] = d[w-1];
            end else begin
                r[i] = 1'b0;
            end
        end
        return r;
    endfunction

    function automatic int ref_lat(input int amt, input logic [1:0] op, input int step);
        if (amt == 0 || op == OP_PASS) return 1;
        return (amt + step - 1) / step + 1;
    endfunction

    task automatic run_a(input logic [7:0] d, input int amt, input logic [1:0] op,
                         input logic dir, input int hold,
                         output logic [7:0] res, output int lat);
        int guard;
        @(negedge clk);
        guard = 0;
        while (!a_in_ready && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        check("a_ready_before_accept", a_in_ready, 1);
        a_in_valid = 1'b1;
        a_in_data  = d;
        a_in_amt   = 3'(amt);
        a_in_op    = op;
        a_in_dir   = dir;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        a_in_data  = 8'($urandom);
        a_in_amt   = 3'($urandom);
        a_in_op    = 2'($urandom);
        a_in_dir   = 1'($urandom);
        lat = 1;
        while (!a_out_valid && lat < 64) begin
            check("a_busy_while_shift", a_busy, 1);
            check("a_in_ready_while_shift", a_in_ready, 0);
            @(posedge clk); #1;
            lat++;
        end
        check("a_out_valid_rise", a_out_valid, 1);
        res = a_out_data;
        for (int h = 0; h < hold; h++) begin
            a_in_valid = 1'b1;
            @(posedge clk); #1;
            check("a_hold_valid", a_out_valid, 1);
            check("a_hold_data", a_out_data, res);
            check("a_hold_in_ready", a_in_ready, 0);
        end
        a_in_valid  = 1'b0;
        a_out_ready = 1'b1;
        @(posedge clk); #1;
        a_out_ready = 1'b0;
        check("a_valid_after_take", a_out_valid, 0);
        check("a_ready_after_take", a_in_ready, 1);
    endtask

    task automatic run_b(input logic [15:0] d, input int amt, input logic [1:0] op,
                         input logic dir, output logic [15:0] res, output int lat);
        @(negedge clk);
        check("b_ready_before_accept", b_in_ready, 1);
        b_in_valid = 1'b1;
        b_in_data  = d;
        b_in_amt   = 4'(amt);
        b_in_op    = op;
        b_in_dir   = dir;
        @(posedge clk); #1;
        b_in_valid = 1'b0;
        b_in_data  = 16'($urandom);
        lat = 1;
        while (!b_out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        check("b_out_valid_rise", b_out_valid, 1);
        res = b_out_data;
        b_out_ready = 1'b1;
        @(posedge clk); #1;
        b_out_ready = 1'b0;
        check("b_valid_after_take", b_out_valid, 0);
    endtask

    logic [7:0]  ra;
    logic [15:0] rb;
    int          lat;
    logic [7:0]  sweep [4][8];
    logic [1:0]  sweep_op  [4] = '{OP_ROT, OP_LOGIC, OP_LOGIC, OP_ARITH};
    logic        sweep_dir [4] = '{DIR_LEFT, DIR_LEFT, DIR_RIGHT, DIR_RIGHT};

    initial begin
        rst = 1'b1;
        a_in_valid = 0; a_in_data = 0; a_in_amt = 0; a_in_op = 0; a_in_dir = 0; a_out_ready = 0;
        b_in_valid = 0; b_in_data = 0; b_in_amt = 0; b_in_op = 0; b_in_dir = 0; b_out_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_out_valid", a_out_valid, 0);
        check("reset_out_data", a_out_data, 0);
        check("reset_busy", a_busy, 0);
        check("reset_in_ready_in_rst", a_in_ready, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("in_ready_after_rst", a_in_ready, 1);
        check("b_in_ready_after_rst", b_in_ready, 1);

        run_a(8'hF0, 3, OP_ARITH, DIR_RIGHT, 0, ra, lat);
        check("asr3_F0", ra, 8'hFE);
        check("asr3_latency", lat, 4);

        for (int o = 0; o < 4; o++) begin
            for (int amt = 0; amt < 8; amt++) begin
                run_a(8'hF0, amt, sweep_op[o], sweep_dir[o], 0, ra, lat);
                sweep[o][amt] = ra;
                check("sweep_result", ra, ref_shift(16'h00F0, amt, sweep_op[o], sweep_dir[o], 8));
                check("sweep_latency", lat, ref_lat(amt, sweep_op[o], 1));
            end
        end
        check("rotl5_F0", sweep[0][5], 8'h1E);
        check("lsl4_F0", sweep[1][4], 8'h00);
        check("lsr7_F0", sweep[2][7], 8'h01);
        check("asr7_F0", sweep[3][7], 8'hFF);
        check("amt0_F0", sweep[1][0], 8'hF0);

        run_a(8'h3C, 2, OP_LOGIC, DIR_LEFT, 5, ra, lat);
        check("backpressure_result", ra, 8'hF0);

        @(negedge clk);
        a_in_valid = 1'b1; a_in_data = 8'hAA; a_in_amt = 3'd6; a_in_op = OP_LOGIC; a_in_dir = DIR_LEFT;
        @(posedge clk); #1;
        a_in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b1;
        @(posedge clk); #1;
        check("midshift_rst_valid", a_out_valid, 0);
        check("midshift_rst_data", a_out_data, 0);
        check("midshift_rst_busy", a_busy, 0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        check("midshift_rst_in_ready", a_in_ready, 1);
        repeat (8) begin
            @(posedge clk); #1;
            check("no_result_after_rst", a_out_valid, 0);
        end
        run_a(8'h81, 1, OP_ROT, DIR_RIGHT, 0, ra, lat);
        check("rotr1_81", ra, 8'hC0);

        run_a(8'h5A, 5, OP_PASS, DIR_LEFT, 0, ra, lat);
        check("pass_result", ra, 8'h5A);
        check("pass_latency", lat, 1);
        run_a(8'h5A, 5, OP_PASS, DIR_RIGHT, 0, ra, lat);
        check("pass_b2b_result", ra, 8'h5A);
        run_a(8'h96, 2, OP_ROT, DIR_LEFT, 0, ra, lat);
        check("b2b_rotl2", ra, 8'h5A);

        run_b(16'h8001, 9, OP_ARITH, DIR_RIGHT, rb, lat);
        check("w16_asr9", rb, 16'hFFC0);
        check("w16_asr9_latency", lat, 4);
        run_b(16'h8001, 15, OP_ROT, DIR_LEFT, rb, lat);
        check("w16_rotl15", rb, 16'hC000);
        check("w16_rotl15_latency", lat, 5);

        for (int n = 0; n < 40; n++) begin
            logic [7:0] d;
            int amt;
            logic [1:0] op;
            logic dir;
            d   = 8'($urandom);
            amt = int'($urandom_range(0, 7));
            op  = 2'($urandom);
            dir = 1'($urandom);
            run_a(d, amt, op, dir, int'($urandom_range(0, 2)), ra, lat);
            check("rand8_result", ra, ref_shift({8'h00, d}, amt, op, dir, 8));
            check("rand8_latency", lat, ref_lat(amt, op, 1));
        end
        for (int n = 0; n < 30; n++) begin
            logic [15:0] d;
            int amt;
            logic [1:0] op;
            logic dir;
            d   = 16'($urandom);
            amt = int'($urandom_range(0, 15));
            op  = 2'($urandom);
            dir = 1'($urandom);
            run_b(d, amt, op, dir, rb, lat);
            check("rand16_result", rb, ref_shift(d, amt, op, dir, 16));
            check("rand16_latency", lat, ref_lat(amt, op, 4));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
